vga_scanout: RTL and testbench

Read-side counterpart of the pixel writers (`extract_move` → `vga_adapter` plot path). It generates 640x480@60 Hz VGA timing from the 50 MHz system clock and reads the 160x120, 3-bit-colour framebuffer through a synchronous read port. Each stored pixel is replicated 4x horizontally and 4x vertically, and the block drives the DAC pins. It also emits a frame-start pulse so game logic can update positions during vertical blank.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_timing_gen.sv | 78 +++++++
 rtl/vga_scanout.sv | 109 ++++++++++
 tb/tb_vga_scanout.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA scan-out constants, framebuffer geometry and pixel types.
package vga_pkg;

    localparam int unsigned DEF_H_VIS  = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_V_VIS  = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;
    localparam int unsigned DEF_SCALE_SHIFT = 2;

    localparam int unsigned FB_W  = 160;
    localparam int unsigned FB_H  = 120;
    localparam int unsigned FB_AW = 15;
    localparam int unsigned CNT_W = 10;

    // {R,G,B}
    typedef logic [2:0] colour_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    // y*160 + x without a multiplier: 160 = 128 + 32.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [CNT_W-1:0] y,
                                                 input logic [CNT_W-1:0] x);
        logic [FB_AW-1:0] y_ext;
        y_ext = FB_AW'(y);
        return (y_ext << 7) + (y_ext << 5) + FB_AW'(x);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, raster counters, raw sync/visible flags and frame-start pulse.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS  = DEF_H_VIS,
    parameter int unsigned H_FP   = DEF_H_FP,
    parameter int unsigned H_SYNC = DEF_H_SYNC,
    parameter int unsigned H_BP   = DEF_H_BP,
    parameter int unsigned V_VIS  = DEF_V_VIS,
    parameter int unsigned V_FP   = DEF_V_FP,
    parameter int unsigned V_SYNC = DEF_V_SYNC,
    parameter int unsigned V_BP   = DEF_V_BP
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             vis,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

    logic             pix_en_q;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                // Frame wrap rides on the same edge as the line wrap.
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + CNT_W'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_en_q <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
        end else begin
            pix_en_q <= ~pix_en_q;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
        end
    end

    always_comb begin
        pix_en      = pix_en_q;
        h_cnt       = h_cnt_q;
        v_cnt       = v_cnt_q;
        hs_raw      = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs_raw      = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        vis         = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        frame_start = pix_en_q && (h_cnt_q == '0) && (v_cnt_q == V_VIS_C);
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: framebuffer address generation, 2-stage read pipeline and DAC drive.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS       = DEF_H_VIS,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_VIS       = DEF_V_VIS,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT
) (
    input  logic             clk,
    input  logic             reset,
    output logic [FB_AW-1:0] rd_addr,
    input  logic [2:0]       rd_data,
    output logic             frame_start,
    output logic [9:0]       vga_r,
    output logic [9:0]       vga_g,
    output logic [9:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n,
    output logic             vga_sync_n,
    output logic             vga_clk
);

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

    logic             pix_en;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    sync_t            raw;

    vga_timing_gen #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hs_raw      (raw.hs),
        .vs_raw      (raw.vs),
        .vis         (raw.vis),
        .frame_start (frame_start)
    );

    logic [FB_AW-1:0] rd_addr_q, rd_addr_d;
    sync_t            d1_q, d1_d;
    sync_t            out_q, out_d;
    colour_t          colour_q, colour_d;
    logic             vga_clk_q;

    always_comb begin
        rd_addr_d = rd_addr_q;
        d1_d      = d1_q;
        out_d     = out_q;
        colour_d  = colour_q;
        if (pix_en) begin
            // Address is held through blanking so the RAM port stays quiet.
            if (raw.vis) begin
                rd_addr_d = fb_addr(v_cnt >> SCALE_SHIFT, h_cnt >> SCALE_SHIFT);
            end
            d1_d     = raw;
            colour_d = d1_q.vis ? colour_t'(rd_data) : colour_t'(3'b000);
            out_d    = d1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_q <= '0;
            d1_q      <= SYNC_IDLE;
            out_q     <= SYNC_IDLE;
            colour_q  <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            d1_q      <= d1_d;
            out_q     <= out_d;
            colour_q  <= colour_d;
            // Tracks pix_en, so its rising edge lands mid-pixel.
            vga_clk_q <= ~pix_en;
        end
    end

    always_comb begin
        rd_addr     = rd_addr_q;
        vga_r       = {10{colour_q[2]}};
        vga_g       = {10{colour_q[1]}};
        vga_b       = {10{colour_q[0]}};
        vga_hs      = out_q.hs;
        vga_vs      = out_q.vs;
        vga_blank_n = out_q.vis;
        vga_sync_n  = 1'b0;
        vga_clk     = vga_clk_q;
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench: a reduced-raster DUT for full-frame checks plus a default-timing DUT.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam int HT_S = 80;   // 64 + 4 + 8 + 4
    localparam int HT_F = 800;

    localparam int K_S_ADDR = 0, K_S_RGB = 1, K_S_HS = 2, K_S_VS = 3, K_S_BLANK = 4;
    localparam int K_S_FS = 5, K_S_VCLK = 6, K_F_ADDR = 7, K_F_RGB = 8, K_F_HS = 9;
    localparam int K_F_BLANK = 10;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ram_ones = 1'b0;

    logic [FB_AW-1:0] s_addr, f_addr;
    logic [2:0]       s_data, f_data;
    logic [9:0]       s_r, s_g, s_b, f_r, f_g, f_b;
    logic             s_fs, s_hs, s_vs, s_blank, s_sync, s_vclk;
    logic             f_fs, f_hs, f_vs, f_blank, f_sync, f_vclk;

    int   cyc;
    int   n_checks = 0;
    int   n_fail = 0;
    int   fs_count = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(posedge clk) s_data <= ram_ones ? 3'b111 : s_addr[2:0];
    always @(posedge clk) f_data <= f_addr[2:0];

    vga_scanout #(
        .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SCALE_SHIFT(2)
    ) u_small (
        .clk(clk), .reset(reset), .rd_addr(s_addr), .rd_data(s_data),
        .frame_start(s_fs), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_blank),
        .vga_sync_n(s_sync), .vga_clk(s_vclk)
    );

    vga_scanout u_full (
        .clk(clk), .reset(reset), .rd_addr(f_addr), .rd_data(f_data),
        .frame_start(f_fs), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
        .vga_hs(f_hs), .vga_vs(f_vs), .vga_blank_n(f_blank),
        .vga_sync_n(f_sync), .vga_clk(f_vclk)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rep3(input logic [2:0] c);
        return {2'b00, {10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    endfunction

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_S_ADDR:  return 32'(s_addr);
            K_S_RGB:   return {2'b00, s_r, s_g, s_b};
            K_S_HS:    return 32'(s_hs);
            K_S_VS:    return 32'(s_vs);
            K_S_BLANK: return 32'(s_blank);
            K_S_FS:    return 32'(s_fs);
            K_S_VCLK:  return 32'(s_vclk);
            K_F_ADDR:  return 32'(f_addr);
            K_F_RGB:   return {2'b00, f_r, f_g, f_b};
            K_F_HS:    return 32'(f_hs);
            K_F_BLANK: return 32'(f_blank);
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic exp_at(input int c, input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Counter value k is present after clk edge 2k; rd_addr two clk later, pins four.
    task automatic exp_addr(input int ht, input int kind, input int h, input int v, input int a);
        exp_at(2 * (v * ht + h) + 2, kind, a, $sformatf("rd_addr(h=%0d,v=%0d)", h, v));
    endtask

    task automatic exp_pins(input int ht, input bit full, input int h, input int v,
                            input logic [2:0] c, input logic blank);
        int t;
        t = 2 * (v * ht + h) + 4;
        exp_at(t, full ? K_F_RGB : K_S_RGB, rep3(c), $sformatf("rgb(h=%0d,v=%0d)", h, v));
        exp_at(t, full ? K_F_BLANK : K_S_BLANK, 32'(blank),
               $sformatf("blank_n(h=%0d,v=%0d)", h, v));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " rd_addr"}, 32'(s_addr), 32'd0);
        chk({tag, " rgb"}, {2'b00, s_r, s_g, s_b}, 32'd0);
        chk({tag, " vga_hs"}, 32'(s_hs), 32'd1);
        chk({tag, " vga_vs"}, 32'(s_vs), 32'd1);
        chk({tag, " blank_n"}, 32'(s_blank), 32'd0);
        chk({tag, " sync_n"}, 32'(s_sync), 32'd0);
        chk({tag, " vga_clk"}, 32'(s_vclk), 32'd0);
        chk({tag, " frame_start"}, 32'(s_fs), 32'd0);
        chk({tag, " full vga_hs"}, 32'(f_hs), 32'd1);
        chk({tag, " full rd_addr"}, 32'(f_addr), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (!reset && sb[i].cyc == cyc) begin
                chk(sb[i].name, actual(sb[i].kind), sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
        if (!reset && s_fs) fs_count++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset_checks("initial reset");

        // ---- small raster: frame 1 with RAM data = addr[2:0] ----
        exp_at(1, K_S_VCLK, 1, "vga_clk c1");
        exp_at(2, K_S_VCLK, 0, "vga_clk c2");
        exp_at(11, K_S_VCLK, 1, "vga_clk c11");
        exp_at(2, K_S_BLANK, 0, "blank_n pipeline fill");
        exp_pins(HT_S, 0, 0, 0, 3'b000, 1'b1);
        exp_pins(HT_S, 0, 4, 0, 3'b001, 1'b1);
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 64; h++)
                exp_addr(HT_S, K_S_ADDR, h, v, h / 4);
        for (int h = 0; h < 4; h++) exp_addr(HT_S, K_S_ADDR, h, 4, 160);
        exp_addr(HT_S, K_S_ADDR, 63, 4, 175);
        exp_pins(HT_S, 0, 63, 4, 3'b111, 1'b1);
        exp_addr(HT_S, K_S_ADDR, 63, 15, 495);
        exp_pins(HT_S, 0, 63, 15, 3'b111, 1'b1);
        exp_addr(HT_S, K_S_ADDR, 64, 15, 495);
        exp_pins(HT_S, 0, 64, 15, 3'b000, 1'b0);
        exp_at(138, K_S_HS, 1, "hs before sync");
        exp_at(140, K_S_HS, 0, "hs fall line0");
        exp_at(154, K_S_HS, 0, "hs last low");
        exp_at(156, K_S_HS, 1, "hs rise");
        exp_at(298, K_S_HS, 1, "hs before sync line1");
        exp_at(300, K_S_HS, 0, "hs fall line1");
        exp_at(2882, K_S_VS, 1, "vs before sync");
        exp_at(2884, K_S_VS, 0, "vs fall");
        exp_at(3202, K_S_VS, 0, "vs last low");
        exp_at(3204, K_S_VS, 1, "vs rise");
        exp_at(2560, K_S_FS, 0, "frame_start before");
        exp_at(2561, K_S_FS, 1, "frame_start pulse");
        exp_at(2562, K_S_FS, 0, "frame_start after");
        // Frame wrap, then frame 2 with the RAM returning all-ones.
        exp_at(3840, K_S_ADDR, 495, "rd_addr held in vblank");
        exp_at(3842, K_S_ADDR, 0, "rd_addr frame2 origin");
        exp_at(3850, K_S_ADDR, 1, "rd_addr frame2 h=4");
        exp_at(3852, K_S_RGB, rep3(3'b111), "rgb ones visible");
        exp_at(3852, K_S_BLANK, 1, "blank_n ones visible");
        exp_at(3984, K_S_RGB, 0, "rgb ones in hblank");
        exp_at(3984, K_S_BLANK, 0, "blank_n in hblank");
        exp_at(4290, K_S_RGB, rep3(3'b111), "rgb ones line2");

        // ---- default 640x480 timing, first lines ----
        exp_addr(HT_F, K_F_ADDR, 4, 0, 1);
        exp_pins(HT_F, 1, 4, 0, 3'b001, 1'b1);
        exp_addr(HT_F, K_F_ADDR, 639, 0, 159);
        exp_pins(HT_F, 1, 639, 0, 3'b111, 1'b1);
        exp_pins(HT_F, 1, 640, 0, 3'b000, 1'b0);
        exp_at(1314, K_F_HS, 1, "full hs before sync");
        exp_at(1316, K_F_HS, 0, "full hs fall");
        exp_at(1506, K_F_HS, 0, "full hs last low");
        exp_at(1508, K_F_HS, 1, "full hs rise");
        exp_at(2914, K_F_HS, 1, "full hs before sync line1");
        exp_at(2916, K_F_HS, 0, "full hs fall line1");

        @(negedge clk);
        reset = 1'b0;

        while (cyc < 3500) @(negedge clk);
        ram_ones = 1'b1;

        // Mid-frame reset at h=30, v=10 of frame 2 (visible, colour all-ones).
        while (cyc < 5500) @(negedge clk);
        chk("scoreboard drained before reset", 32'(sb.size()), 32'd0);
        chk("frame_start pulses in frame 1", 32'(fs_count), 32'd1);
        chk("visible before reset", {2'b00, s_r, s_g, s_b}, rep3(3'b111));
        #2 reset = 1'b1;
        #1 reset_checks("async reset");
        repeat (3) @(negedge clk);
        fs_count = 0;

        exp_at(10, K_S_ADDR, 1, "restart rd_addr h=4");
        exp_at(12, K_S_RGB, rep3(3'b111), "restart rgb h=4");
        exp_at(138, K_S_HS, 1, "restart hs before sync");
        exp_at(140, K_S_HS, 0, "restart hs fall");
        exp_at(2560, K_S_FS, 0, "restart frame_start before");
        exp_at(2561, K_S_FS, 1, "restart frame_start pulse");
        exp_at(2882, K_S_VS, 1, "restart vs before sync");
        exp_at(2884, K_S_VS, 0, "restart vs fall");
        exp_at(10, K_F_ADDR, 1, "restart full rd_addr h=4");
        exp_at(1316, K_F_HS, 0, "restart full hs fall");
        reset = 1'b0;

        while (cyc < 2950) @(negedge clk);
        chk("scoreboard drained at end", 32'(sb.size()), 32'd0);
        chk("frame_start pulses after restart", 32'(fs_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
